// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: one TMDS receive channel in the recovered pixel-clock domain.
// It takes raw 10-bit deserializer words of unknown bit alignment and finds the
// symbol boundary by hunting for runs of control tokens. Each aligned symbol is
// then decoded into blanking control bits or an 8-bit active-video byte.
// Streaming interface: one word is accepted on every rising edge and one decoded
// symbol is produced on every rising edge. There is no valid/ready handshake and
// no stall path. o_locked is the FSM state (1 = LOCKED, 0 = SEARCH).
module tmds_rx_channel #(
  parameter int LOCK_TOKENS   = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int MAX_RUN       = 2048
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_word,
  output logic       o_de,
  output logic [1:0] o_c,
  output logic [7:0] o_data,
  output logic       o_locked,
  output logic [3:0] o_offset,
  output logic       o_ctl
);

  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  localparam logic [TOK_W-1:0] TOK_LIMIT = TOK_W'(LOCK_TOKENS);
  localparam logic [WIN_W-1:0] WIN_LIMIT = WIN_W'(SEARCH_WINDOW);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [9:0]         prev, sym;
  logic [19:0]        cat_shift;
  logic [3:0]         offset, offset_d;
  logic               holdoff, holdoff_d;
  logic               slip;
  logic [TOK_W-1:0]   tok_cnt, tok_d;
  logic [WIN_W-1:0]   win_cnt, win_d;
  logic [RUN_W-1:0]   run_cnt, run_d;
  logic               match;
  logic [1:0]         code;
  logic [7:0]         q, d;

  // Two-word window shifted so the chosen alignment lands in the low 10 bits.
  always_comb begin
    cat_shift = {i_word, prev} >> offset;
  end

  // Stage 1: remember the previous word and capture the aligned symbol.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev <= '0;
      sym  <= '0;
    end else begin
      prev <= i_word;
      sym  <= cat_shift[9:0];
    end
  end

  // Whole-word match against the four control tokens.
  always_comb begin
    match = 1'b1;
    code  = 2'b00;
    case (sym)
      10'h354: code = 2'b00;
      10'h0AB: code = 2'b01;
      10'h154: code = 2'b10;
      10'h2AB: code = 2'b11;
      default: match = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9) and the XOR/XNOR chain (bit 8).
  always_comb begin
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d    = 8'h00;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Alignment FSM: next state, counters and slip decision.
  always_comb begin
    state_d   = state;
    offset_d  = offset;
    tok_d     = tok_cnt;
    win_d     = win_cnt;
    run_d     = run_cnt;
    holdoff_d = 1'b0;
    slip      = 1'b0;
    // The symbol right after a slip was cut at the old offset, so it is skipped.
    if (!holdoff) begin
      case (state)
        ST_SEARCH: begin
          if (match) tok_d = (tok_cnt == '1) ? tok_cnt : tok_cnt + TOK_W'(1);
          else       tok_d = '0;
          win_d = (win_cnt == '1) ? win_cnt : win_cnt + WIN_W'(1);
          // Lock wins over a window expiry on the same symbol.
          if (tok_d == TOK_LIMIT) begin
            state_d = ST_LOCKED;
            tok_d   = '0;
            win_d   = '0;
            run_d   = '0;
          end else if (win_d == WIN_LIMIT) begin
            slip = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (match) run_d = '0;
          else       run_d = (run_cnt == '1) ? run_cnt : run_cnt + RUN_W'(1);
          if (run_d == RUN_LIMIT) begin
            state_d = ST_SEARCH;
            slip    = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    if (slip) begin
      offset_d  = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
      tok_d     = '0;
      win_d     = '0;
      run_d     = '0;
      holdoff_d = 1'b1;
    end
  end

  // FSM and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_SEARCH;
      offset  <= 4'd0;
      holdoff <= 1'b0;
      tok_cnt <= '0;
      win_cnt <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_d;
      offset  <= offset_d;
      holdoff <= holdoff_d;
      tok_cnt <= tok_d;
      win_cnt <= win_d;
      run_cnt <= run_d;
    end
  end

  // Stage 2: decoded outputs, gated by the lock state being entered this edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ctl  <= 1'b0;
      o_de   <= 1'b0;
      o_c    <= 2'b00;
      o_data <= 8'h00;
    end else begin
      o_ctl <= match;
      if (state_d == ST_LOCKED) begin
        o_de <= ~match;
        if (match) o_c <= code;
        o_data <= match ? 8'h00 : d;
      end else begin
        o_de   <= 1'b0;
        o_c    <= 2'b00;
        o_data <= 8'h00;
      end
    end
  end

  assign o_locked = (state == ST_LOCKED);
  assign o_offset = offset;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb_tmds_rx_channel: directed-plus-random bench for tmds_rx_channel with a
// symbol-level reference model and an expected-output queue.
module tb_tmds_rx_channel;

  localparam int LOCK_TOKENS   = 16;
  localparam int SEARCH_WINDOW = 2048;
  localparam int MAX_RUN       = 2048;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       i_rst;
  logic [9:0] i_word;
  logic       o_de;
  logic [1:0] o_c;
  logic [7:0] o_data;
  logic       o_locked;
  logic [3:0] o_offset;
  logic       o_ctl;

  always #5 clk = ~clk;

  tmds_rx_channel #(
    .LOCK_TOKENS(LOCK_TOKENS),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .MAX_RUN(MAX_RUN)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_word(i_word),
    .o_de(o_de),
    .o_c(o_c),
    .o_data(o_data),
    .o_locked(o_locked),
    .o_offset(o_offset),
    .o_ctl(o_ctl)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  int off_cyc_q[$];
  int off_val_q[$];
  logic       prev_locked = 1'b0;
  logic [3:0] prev_off = 4'd0;

  // ---------------- reference model ----------------
  logic [16:0] exp_q[$];
  logic [9:0]  m_prev = '0;
  logic [9:0]  m_sym = '0;
  int          m_off = 0;
  int          m_tok = 0;
  int          m_win = 0;
  int          m_run = 0;
  bit          m_lock = 0;
  bit          m_hold = 0;
  logic        e_de = 0;
  logic [1:0]  e_c = 0;
  logic [7:0]  e_data = 0;
  logic        e_ctl = 0;

  function automatic bit tok_lookup(input logic [9:0] s, output logic [1:0] c);
    logic [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    c = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (s == toks[i]) begin
        c = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] r;
    logic x;
    q = s[9] ? ~s[7:0] : s[7:0];
    r = 8'h00;
    r[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      x = q[i] ^ q[i-1];
      r[i] = s[8] ? x : ~x;
    end
    return r;
  endfunction

  task automatic model_edge(input logic [9:0] w, input logic rst);
    logic [19:0] cat;
    logic [9:0]  nxt;
    logic [1:0]  code;
    bit          is_t;
    bit          slip;
    if (rst) begin
      m_prev = '0; m_sym = '0; m_off = 0;
      m_tok = 0; m_win = 0; m_run = 0;
      m_lock = 0; m_hold = 0;
      e_de = 0; e_c = 0; e_data = 0; e_ctl = 0;
    end else begin
      cat  = {w, m_prev};
      nxt  = cat[m_off +: 10];
      is_t = tok_lookup(m_sym, code);
      slip = 0;
      if (m_hold) begin
        m_hold = 0;
      end else if (!m_lock) begin
        m_tok = is_t ? m_tok + 1 : 0;
        m_win = m_win + 1;
        if (m_tok >= LOCK_TOKENS) begin
          m_lock = 1; m_tok = 0; m_win = 0; m_run = 0;
        end else if (m_win >= SEARCH_WINDOW) begin
          slip = 1;
        end
      end else begin
        m_run = is_t ? 0 : m_run + 1;
        if (m_run >= MAX_RUN) begin
          m_lock = 0;
          slip = 1;
        end
      end
      if (slip) begin
        m_off = (m_off + 1) % 10;
        m_tok = 0; m_win = 0; m_run = 0;
        m_hold = 1;
      end
      e_ctl = is_t;
      if (m_lock) begin
        e_de = !is_t;
        if (is_t) e_c = code;
        e_data = is_t ? 8'h00 : tmds_decode(m_sym);
      end else begin
        e_de = 0; e_c = 0; e_data = 0;
      end
      m_prev = w;
      m_sym  = nxt;
    end
    exp_q.push_back({e_de, e_c, e_data, m_lock, 4'(m_off), e_ctl});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [9:0] w, input logic rst);
    logic [16:0] exp_v;
    i_word = w;
    i_rst  = rst;
    @(posedge clk);
    model_edge(w, rst);
    #1;
    cyc++;
    exp_v = exp_q.pop_front();
    check("cycle", 32'({o_de, o_c, o_data, o_locked, o_offset, o_ctl}), 32'(exp_v));
    if (o_locked && !prev_locked) rise_cyc = cyc;
    if (!o_locked && prev_locked) fall_cyc = cyc;
    if (o_offset != prev_off) begin
      off_cyc_q.push_back(cyc);
      off_val_q.push_back(int'(o_offset));
    end
    prev_locked = o_locked;
    prev_off    = o_offset;
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] v;
    logic [1:0] c;
    do v = 10'($urandom_range(0, 1023)); while (tok_lookup(v, c));
    return v;
  endfunction

  // One 800-symbol line: 160 blanking tokens then 640 data symbols.
  function automatic logic [9:0] line_sym(input int m);
    int p;
    p = m % 800;
    if (p < 160)  return 10'h354;
    if (p == 160) return 10'h1FF;
    if (p == 161) return 10'h300;
    if (p == 162) return 10'h0FF;
    return rand_data();
  endfunction

  bit bq[$];

  task automatic push_sym(input logic [9:0] s);
    for (int b = 0; b < 10; b++) bq.push_back(s[b]);
  endtask

  function automatic logic [9:0] pop_word();
    logic [9:0] w;
    for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
    return w;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int m_idx;
    bit seen9;
    bit done;
    logic [9:0] seq [$];
    logic [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    i_rst  = 1'b1;
    i_word = '0;

    // Reset with random words on the input.
    for (int k = 0; k < 5; k++) step(10'($urandom_range(0, 1023)), 1'b1);
    check("rst_outputs", 32'({o_de, o_c, o_data, o_locked, o_offset, o_ctl}), 32'd0);

    // Aligned stream: two lines at offset 0.
    base = cyc;
    for (int j = 0; j < 1600; j++) begin
      step(line_sym(j), 1'b0);
      if (j == 16)  check("unlocked_before_16th", 32'(o_locked), 32'd0);
      if (j == 162) check("dec_1ff", 32'({o_de, o_data}), 32'({1'b1, 8'h01}));
      if (j == 163) check("dec_300", 32'({o_de, o_data}), 32'({1'b1, 8'h01}));
      if (j == 164) check("dec_0ff", 32'({o_de, o_data}), 32'({1'b1, 8'hFF}));
      if (j == 805) check("blank_c00", 32'({o_locked, o_de, o_c, o_ctl}), 32'({1'b1, 1'b0, 2'b00, 1'b1}));
    end
    check("lock_rise_step", 32'(rise_cyc - base - 1), 32'd17);

    // Control decode followed by 2048 consecutive data symbols (loss of lock).
    for (int k = 0; k < 4; k++) seq.push_back(toks[k]);
    for (int k = 0; k < 2052; k++) seq.push_back(rand_data());
    base = cyc;
    for (int i = 0; i < seq.size(); i++) begin
      step(seq[i], 1'b0);
      if (i >= 2 && i < 6)
        check("ctl_decode", 32'({o_de, o_ctl, o_c}), 32'({1'b0, 1'b1, 2'(i - 2)}));
      if (i == 2052) check("still_locked", 32'(o_locked), 32'd1);
      if (i == 2053) check("lock_drop", 32'({o_locked, o_offset, o_de}), 32'({1'b0, 4'd1, 1'b0}));
      if (i == 2055) check("de_after_drop", 32'(o_de), 32'd0);
    end
    check("lock_drop_step", 32'(fall_cyc - base - 1), 32'd2053);

    // Misaligned stream: symbols start at word bit 7.
    step(10'($urandom_range(0, 1023)), 1'b1);
    step(10'($urandom_range(0, 1023)), 1'b1);
    off_cyc_q.delete();
    off_val_q.delete();
    rise_cyc = -1;
    for (int b = 0; b < 7; b++) bq.push_back(1'($urandom_range(0, 1)));
    m_idx = 0;
    base = cyc;
    for (int n = 0; n < 15200; n++) begin
      while (bq.size() < 10) begin
        push_sym(line_sym(m_idx));
        m_idx++;
      end
      step(pop_word(), 1'b0);
    end
    check("mis_slip_count", 32'(off_cyc_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < off_cyc_q.size(); i++) begin
      check("mis_slip_step", 32'(off_cyc_q[i] - base - 1), 32'(2047 + 2049 * i));
      check("mis_slip_val", 32'(off_val_q[i]), 32'(i + 1));
    end
    check("mis_locked", 32'({o_locked, o_offset}), 32'({1'b1, 4'd7}));
    check("mis_lock_seen", 32'(rise_cyc > base), 32'd1);

    // Wrap: data-only stream forces lock loss and repeated slips 8 -> 9 -> 0.
    seen9 = 0;
    done  = 0;
    for (int n = 0; n < 8000 && !done; n++) begin
      while (bq.size() < 10) push_sym(rand_data());
      step(pop_word(), 1'b0);
      if (o_offset == 4'd9) seen9 = 1;
      if (seen9 && o_offset == 4'd0) done = 1;
    end
    check("wrap_9_to_0", 32'({seen9, done, o_locked}), 32'({1'b1, 1'b1, 1'b0}));

    // Mid-lock reset.
    step(10'h354, 1'b1);
    step(10'h354, 1'b1);
    for (int k = 0; k < 20; k++) step(10'h354, 1'b0);
    check("relocked", 32'({o_locked, o_offset, o_ctl}), 32'({1'b1, 4'd0, 1'b1}));
    step(10'h354, 1'b1);
    check("midlock_rst", 32'({o_de, o_c, o_data, o_locked, o_offset, o_ctl}), 32'd0);
    step(10'h354, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
